// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_pkg                                                   |
// | Description : Shared types and constants for the pipeline hazard block.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package hazard_pkg;

  // Execute-stage operand source select
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e_t;

  // Writeback source code meaning "data memory" (i.e. a load)
  localparam logic [1:0] DM2REG_MEM = 2'b01;

  // Mult/div sequencer states
  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // A later stage supplies register ra when it writes a non-zero matching register
  function automatic logic reg_hit(input logic we, input logic [4:0] wa, input logic [4:0] ra);
    return we && (wa != 5'd0) && (wa == ra);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_ctrl_if                                               |
// | Description : Pipeline-side signal bundle of the hazard controller.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface hazard_ctrl_if;
  // decode stage
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic       branch_d;
  logic       j_src_d;
  logic       hilo_rd_d;
  logic       md_op_d;
  // execute stage
  logic [4:0] rse;
  logic [4:0] rte;
  logic [4:0] rf_wae;
  logic       we_rege;
  logic [1:0] dm2rege;
  logic       hilo_wee;
  // memory stage
  logic [4:0] rf_wam;
  logic       we_regm;
  logic [1:0] dm2regm;
  // writeback stage
  logic [4:0] rf_waw;
  logic       we_regw;
  // controls back to the pipeline
  logic       stall_f;
  logic       stall_d;
  logic       flush_e;
  logic       forward_ad;
  logic       forward_bd;
  logic [1:0] forward_ae;
  logic [1:0] forward_be;
  logic       md_start;
  logic       md_busy;
  logic       md_done;

  // pipeline side
  modport master (
    output rs_d, rt_d, branch_d, j_src_d, hilo_rd_d, md_op_d,
    output rse, rte, rf_wae, we_rege, dm2rege, hilo_wee,
    output rf_wam, we_regm, dm2regm, rf_waw, we_regw,
    input  stall_f, stall_d, flush_e, forward_ad, forward_bd,
    input  forward_ae, forward_be, md_start, md_busy, md_done
  );

  // hazard controller side
  modport slave (
    input  rs_d, rt_d, branch_d, j_src_d, hilo_rd_d, md_op_d,
    input  rse, rte, rf_wae, we_rege, dm2rege, hilo_wee,
    input  rf_wam, we_regm, dm2regm, rf_waw, we_regw,
    output stall_f, stall_d, flush_e, forward_ad, forward_bd,
    output forward_ae, forward_be, md_start, md_busy, md_done
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_md_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : md_seq                                                       |
// | Description : Mult/div launch sequencer with down-counter, plus the stall  |
// |               term that holds HI/LO readers and new mult/div ops in D.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module md_seq
  import hazard_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic hilo_wee,
  input  logic hilo_rd_d,
  input  logic md_op_d,
  output logic md_start,
  output logic md_busy,
  output logic md_done,
  output logic md_stall
);

  // Counter reload gives md_done exactly MD_CYCLES cycles after md_start
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(MD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  md_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;

  // Sequencer: launch from IDLE on hilo_wee, count down in BUSY, return on zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (hilo_wee) begin
            r_state <= MD_BUSY;
            r_cnt   <= C_CNT_LOAD;
          end
        end
        MD_BUSY: begin
          // A hilo_wee here cannot legally happen and is ignored
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - C_CNT_ONE;
          end else begin
            r_state <= MD_IDLE;
          end
        end
      endcase
    end
  end

  // Pulses are decoded from registered state; reset suppresses them so an
  // aborted operation never reports completion
  assign md_busy  = (r_state == MD_BUSY);
  assign md_start = !rst && (r_state == MD_IDLE) && hilo_wee;
  assign md_done  = !rst && md_busy && (r_cnt == '0);

  // Covers launch cycle through the done cycle so readers see the new HI/LO
  assign md_stall = !rst && (hilo_rd_d || md_op_d) && (md_busy || hilo_wee);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_ctrl                                                  |
// | Description : Forwarding, load-use/branch/jr stall decode and mult/div     |
// |               scheduling for the 5-stage pipeline.                         |
// |               Optional macro HAZARD_PERF_EN adds stall_cnt / md_cnt.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]  stall_cnt,
  output logic [31:0]  md_cnt
`endif
);

  fwd_e_t w_fwd_ae;
  fwd_e_t w_fwd_be;
  logic   w_fwd_ad;
  logic   w_fwd_bd;
  logic   w_lw_stall;
  logic   w_br_stall;
  logic   w_jr_stall;
  logic   w_md_stall;
  logic   w_stall;
  logic   w_e_rs;
  logic   w_e_rt;
  logic   w_m_rs;
  logic   w_m_rt;
  logic   w_md_start;

  // Forward selects and load-use/branch/jr stall terms; MEM beats WB
  always_comb begin
    w_fwd_ae = FWD_RF;
    w_fwd_be = FWD_RF;
    if (reg_hit(hz.we_regm, hz.rf_wam, hz.rse)) begin
      w_fwd_ae = FWD_MEM;
    end else if (reg_hit(hz.we_regw, hz.rf_waw, hz.rse)) begin
      w_fwd_ae = FWD_WB;
    end
    if (reg_hit(hz.we_regm, hz.rf_wam, hz.rte)) begin
      w_fwd_be = FWD_MEM;
    end else if (reg_hit(hz.we_regw, hz.rf_waw, hz.rte)) begin
      w_fwd_be = FWD_WB;
    end

    w_fwd_ad = reg_hit(hz.we_regm, hz.rf_wam, hz.rs_d);
    w_fwd_bd = reg_hit(hz.we_regm, hz.rf_wam, hz.rt_d);

    // Producer in E (any write) or a load in M is too late for the D comparator
    w_e_rs = reg_hit(hz.we_rege, hz.rf_wae, hz.rs_d);
    w_e_rt = reg_hit(hz.we_rege, hz.rf_wae, hz.rt_d);
    w_m_rs = reg_hit(hz.dm2regm == DM2REG_MEM, hz.rf_wam, hz.rs_d);
    w_m_rt = reg_hit(hz.dm2regm == DM2REG_MEM, hz.rf_wam, hz.rt_d);

    w_lw_stall = (hz.dm2rege == DM2REG_MEM) && (w_e_rs || w_e_rt);
    w_br_stall = hz.branch_d && (w_e_rs || w_e_rt || w_m_rs || w_m_rt);
    w_jr_stall = hz.j_src_d && (w_e_rs || w_m_rs);
    w_stall    = w_lw_stall || w_br_stall || w_jr_stall || w_md_stall;
  end

  md_seq #(
    .MD_CYCLES (MD_CYCLES),
    .CNT_W     (CNT_W)
  ) u_md_seq (
    .clk       (clk),
    .rst       (rst),
    .hilo_wee  (hz.hilo_wee),
    .hilo_rd_d (hz.hilo_rd_d),
    .md_op_d   (hz.md_op_d),
    .md_start  (w_md_start),
    .md_busy   (hz.md_busy),
    .md_done   (hz.md_done),
    .md_stall  (w_md_stall)
  );

  assign hz.md_start   = w_md_start;
  assign hz.stall_f    = !rst && w_stall;
  assign hz.stall_d    = !rst && w_stall;
  assign hz.flush_e    = !rst && w_stall;
  assign hz.forward_ad = !rst && w_fwd_ad;
  assign hz.forward_bd = !rst && w_fwd_bd;
  assign hz.forward_ae = rst ? FWD_RF : w_fwd_ae;
  assign hz.forward_be = rst ? FWD_RF : w_fwd_be;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_md_cnt;

  // Free-running event counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_md_cnt    <= '0;
    end else begin
      if (hz.stall_d) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_md_start) begin
        r_md_cnt <= r_md_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign md_cnt    = r_md_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hazard_ctrl                                               |
// | Description : Self-checking bench for hazard_ctrl (MD_CYCLES=4 and 1).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic       branch_d;
    logic       j_src_d;
    logic [4:0] rse;
    logic [4:0] rte;
    logic [4:0] rf_wae;
    logic       we_rege;
    logic [1:0] dm2rege;
    logic [4:0] rf_wam;
    logic       we_regm;
    logic [1:0] dm2regm;
    logic [4:0] rf_waw;
    logic       we_regw;
    logic [6:0] exp; // {stall, fwd_ad, fwd_bd, fwd_ae[1:0], fwd_be[1:0]}
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  vec_t       tbl[$];
  logic [6:0] sb_dec[$];
  logic [3:0] sb_md[$];   // {md_start, md_busy, md_done, stall_d}

  always #5 clk = ~clk;

  hazard_ctrl_if bus4 ();
  hazard_ctrl_if bus1 ();

`ifdef HAZARD_PERF_EN
  logic [31:0] sc4, mc4, sc1, mc1;
`endif

  hazard_ctrl #(.MD_CYCLES(4), .CNT_W(8)) u_dut4 (
    .clk (clk), .rst (rst), .hz (bus4)
`ifdef HAZARD_PERF_EN
    , .stall_cnt (sc4), .md_cnt (mc4)
`endif
  );

  hazard_ctrl #(.MD_CYCLES(1), .CNT_W(2)) u_dut1 (
    .clk (clk), .rst (rst), .hz (bus1)
`ifdef HAZARD_PERF_EN
    , .stall_cnt (sc1), .md_cnt (mc1)
`endif
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive4(input vec_t v);
    bus4.rs_d = v.rs_d;       bus4.rt_d = v.rt_d;
    bus4.branch_d = v.branch_d; bus4.j_src_d = v.j_src_d;
    bus4.rse = v.rse;         bus4.rte = v.rte;
    bus4.rf_wae = v.rf_wae;   bus4.we_rege = v.we_rege;  bus4.dm2rege = v.dm2rege;
    bus4.rf_wam = v.rf_wam;   bus4.we_regm = v.we_regm;  bus4.dm2regm = v.dm2regm;
    bus4.rf_waw = v.rf_waw;   bus4.we_regw = v.we_regw;
    bus4.hilo_rd_d = 1'b0;    bus4.md_op_d = 1'b0;       bus4.hilo_wee = 1'b0;
  endtask

  task automatic zero1();
    bus1.rs_d = '0; bus1.rt_d = '0; bus1.branch_d = 1'b0; bus1.j_src_d = 1'b0;
    bus1.rse = '0; bus1.rte = '0; bus1.rf_wae = '0; bus1.we_rege = 1'b0; bus1.dm2rege = '0;
    bus1.rf_wam = '0; bus1.we_regm = 1'b0; bus1.dm2regm = '0;
    bus1.rf_waw = '0; bus1.we_regw = 1'b0;
    bus1.hilo_rd_d = 1'b0; bus1.md_op_d = 1'b0; bus1.hilo_wee = 1'b0;
  endtask

  function automatic logic [8:0] act4();
    return {bus4.stall_f, bus4.stall_d, bus4.flush_e, bus4.forward_ad, bus4.forward_bd,
            bus4.forward_ae, bus4.forward_be};
  endfunction

  task automatic add(input vec_t v, input logic [6:0] e);
    vec_t t;
    t = v;
    t.exp = e;
    tbl.push_back(t);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t       v;
    logic [6:0] e;
    logic [3:0] m;
    logic [3:0] md1_exp[6];
    logic [2:0] md1_in[6];   // {hilo_wee, md_op_d, hilo_rd_d}

    // ---------------- decode vectors ----------------
    v = '0; add(v, 7'b0_0_0_00_00);
    v = '0; v.we_regm = 1; v.rf_wam = 8; v.rse = 8; v.we_regw = 1; v.rf_waw = 8; add(v, 7'b0_0_0_10_00);
    v = '0; v.we_regm = 1; v.rf_wam = 0; v.rse = 0; v.we_regw = 1; v.rf_waw = 0; add(v, 7'b0_0_0_00_00);
    v = '0; v.we_regw = 1; v.rf_waw = 5; v.rse = 5; v.rte = 5; add(v, 7'b0_0_0_01_01);
    v = '0; v.we_regm = 1; v.rf_wam = 3; v.rte = 3; v.we_regw = 1; v.rf_waw = 7; v.rse = 7; add(v, 7'b0_0_0_01_10);
    v = '0; v.we_regm = 0; v.rf_wam = 8; v.rse = 8; add(v, 7'b0_0_0_00_00);
    v = '0; v.we_regm = 1; v.rf_wam = 6; v.rs_d = 6; v.rt_d = 6; add(v, 7'b0_1_1_00_00);
    // load-use, then the load has moved to MEM and the consumer to E
    v = '0; v.we_rege = 1; v.dm2rege = 2'b01; v.rf_wae = 9; v.rt_d = 9; add(v, 7'b1_0_0_00_00);
    v = '0; v.we_regm = 1; v.rf_wam = 9; v.dm2regm = 2'b01; v.rte = 9; add(v, 7'b0_0_0_00_10);
    v = '0; v.we_rege = 1; v.dm2rege = 2'b01; v.rf_wae = 0; add(v, 7'b0_0_0_00_00);
    v = '0; v.we_rege = 1; v.dm2rege = 2'b00; v.rf_wae = 9; v.rt_d = 9; add(v, 7'b0_0_0_00_00);
    v = '0; v.we_rege = 1; v.dm2rege = 2'b01; v.rf_wae = 12; v.rs_d = 12; add(v, 7'b1_0_0_00_00);
    // branch: ALU producer in E stalls, then forwards from MEM
    v = '0; v.branch_d = 1; v.rs_d = 4; v.we_rege = 1; v.rf_wae = 4; add(v, 7'b1_0_0_00_00);
    v = '0; v.branch_d = 1; v.rs_d = 4; v.we_regm = 1; v.rf_wam = 4; add(v, 7'b0_1_0_00_00);
    v = '0; v.branch_d = 1; v.rt_d = 10; v.we_regm = 1; v.rf_wam = 10; v.dm2regm = 2'b01; add(v, 7'b1_0_1_00_00);
    v = '0; v.branch_d = 1; v.rs_d = 4; v.we_rege = 0; v.rf_wae = 4; add(v, 7'b0_0_0_00_00);
    v = '0; v.branch_d = 1; v.we_rege = 1; v.rf_wae = 0; v.dm2regm = 2'b01; add(v, 7'b0_0_0_00_00);
    // jr reads rs only
    v = '0; v.j_src_d = 1; v.rt_d = 4; v.we_rege = 1; v.rf_wae = 4; add(v, 7'b0_0_0_00_00);
    v = '0; v.j_src_d = 1; v.rs_d = 4; v.we_rege = 1; v.rf_wae = 4; add(v, 7'b1_0_0_00_00);
    v = '0; v.j_src_d = 1; v.rs_d = 11; v.we_regm = 1; v.rf_wam = 11; v.dm2regm = 2'b01; add(v, 7'b1_1_0_00_00);

    // ---------------- reset: outputs forced low ----------------
    zero1();
    v = '0; v.we_rege = 1; v.dm2rege = 2'b01; v.rf_wae = 9; v.rt_d = 9;
    v.we_regm = 1; v.rf_wam = 8; v.rse = 8; v.rs_d = 8;
    drive4(v);
    bus4.hilo_wee = 1'b1; bus4.hilo_rd_d = 1'b1;
    bus1.hilo_wee = 1'b1; bus1.md_op_d = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("reset_dec", {7'd0, act4()}, 16'd0);
    chk("reset_md4", {13'd0, bus4.md_start, bus4.md_busy, bus4.md_done}, 16'd0);
    chk("reset_md1", {12'd0, bus1.md_start, bus1.md_busy, bus1.md_done, bus1.stall_d}, 16'd0);
    next_cycle();
    rst = 1'b0;
    zero1();

    // ---------------- table-driven decode ----------------
    foreach (tbl[i]) begin
      drive4(tbl[i]);
      sb_dec.push_back(tbl[i].exp);
      @(negedge clk);
      e = sb_dec.pop_front();
      chk($sformatf("dec%0d", i), {7'd0, act4()}, {7'd0, e[6], e[6], e});
      next_cycle();
    end

    // ---------------- mult/div, MD_CYCLES=4, mfhi waiting in D ----------------
    for (int k = 0; k <= 6; k++) begin
      drive4('0);
      bus4.hilo_wee  = (k == 0);
      bus4.hilo_rd_d = 1'b1;
      sb_md.push_back({k == 0, (k >= 1) && (k <= 4), k == 4, k <= 4});
      @(negedge clk);
      m = sb_md.pop_front();
      chk($sformatf("md4_c%0d", k), {12'd0, bus4.md_start, bus4.md_busy, bus4.md_done, bus4.stall_d}, {12'd0, m});
      next_cycle();
    end

    // ---------------- reset during BUSY aborts the operation ----------------
    for (int k = 0; k <= 8; k++) begin
      drive4('0);
      bus4.hilo_wee  = (k == 0);
      bus4.hilo_rd_d = 1'b1;
      rst = (k == 2);
      sb_md.push_back({k == 0, k == 1, 1'b0, k <= 1});
      @(negedge clk);
      m = sb_md.pop_front();
      if (k == 2) begin
        chk("md_rst_cyc", {13'd0, bus4.md_start, bus4.md_done, bus4.stall_d}, {13'd0, m[3], m[1], m[0]});
      end else begin
        chk($sformatf("md_rst_c%0d", k), {12'd0, bus4.md_start, bus4.md_busy, bus4.md_done, bus4.stall_d}, {12'd0, m});
      end
      next_cycle();
    end
    rst = 1'b0;
    drive4('0);

    // ---------------- MD_CYCLES=1, back-to-back mult ----------------
    md1_in[0] = 3'b110; md1_exp[0] = 4'b1001;
    md1_in[1] = 3'b010; md1_exp[1] = 4'b0111;
    md1_in[2] = 3'b010; md1_exp[2] = 4'b0000;
    md1_in[3] = 3'b100; md1_exp[3] = 4'b1000;
    md1_in[4] = 3'b000; md1_exp[4] = 4'b0110;
    md1_in[5] = 3'b000; md1_exp[5] = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      zero1();
      bus1.hilo_wee  = md1_in[k][2];
      bus1.md_op_d   = md1_in[k][1];
      bus1.hilo_rd_d = md1_in[k][0];
      sb_md.push_back(md1_exp[k]);
      @(negedge clk);
      m = sb_md.pop_front();
      chk($sformatf("md1_c%0d", k), {12'd0, bus1.md_start, bus1.md_busy, bus1.md_done, bus1.stall_d}, {12'd0, m});
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Produces forward selects for the decode-stage comparator and the execute-stage operand muxes.
- Produces load-use and branch/jr stall and flush controls.
- Schedules the multi-cycle multiply/divide unit: launches it when a HI/LO-writing op is in E, and holds HI/LO readers in D until the result is written.

Parameters:
- MD_CYCLES, 32, execute cycles of the mult/div unit after launch; legal 1..255.
- CNT_W, 8, width of the mult/div down-counter; must satisfy 2^CNT_W > MD_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rs_d  in  5  instr[25:21] in decode
- rt_d  in  5  instr[20:16] in decode
- branch_d  in  1  beq in decode
- j_src_d  in  1  jr in decode (reads rs only)
- hilo_rd_d  in  1  mfhi/mflo in decode
- md_op_d  in  1  mult/div in decode
- rse  in  5  rs in execute
- rte  in  5  rt in execute
- rf_wae  in  5  destination register in execute
- we_rege  in  1  register write in execute
- dm2rege  in  2  writeback source in execute
- hilo_wee  in  1  mult/div in execute
- rf_wam  in  5  destination register in memory
- we_regm  in  1  register write in memory
- dm2regm  in  2  writeback source in memory
- rf_waw  in  5  destination register in writeback
- we_regw  in  1  register write in writeback
- stall_f  out  1  hold PC
- stall_d  out  1  hold ID register
- flush_e  out  1  clear EXE register
- forward_ad  out  1  1 = alu_outm into rd1 comparator
- forward_bd  out  1  1 = alu_outm into rd2 comparator
- forward_ae  out  2  00 = RF, 01 = wd_rf (WB), 10 = alu_outm (MEM)
- forward_be  out  2  same encoding as forward_ae
- md_start  out  1  one-cycle launch pulse to the mult/div unit
- md_busy  out  1  mult/div in progress
- md_done  out  1  one-cycle pulse; HI/LO write enable

Behaviour:
- Forwarding and stall decode is combinational; only the mult/div sequencer is registered.
- Register 0 is never a forwarding source and never causes a stall.
- forward_ae:
  - = 10 if we_regm && rf_wam != 0 && rf_wam == rse.
  - else = 01 if we_regw && rf_waw != 0 && rf_waw == rse.
  - else = 00.
  - MEM has priority over WB. forward_be is the same using rte.
- forward_ad = we_regm && rf_wam != 0 && rf_wam == rs_d. forward_bd is the same using rt_d.
- lw_stall = we_rege && dm2rege == DM2REG_MEM && rf_wae != 0 && (rf_wae == rs_d || rf_wae == rt_d).
- br_stall = branch_d && one of:
  - we_rege && rf_wae != 0 && rf_wae matches rs_d or rt_d;
  - dm2regm == DM2REG_MEM && rf_wam != 0 && rf_wam matches rs_d or rt_d.
- jr_stall: same conditions as br_stall, gated by j_src_d and matching rs_d only.
- Mult/div sequencer FSM, states IDLE and BUSY; cnt is CNT_W bits.
  - IDLE, hilo_wee=1: md_start=1, cnt <= MD_CYCLES-1, go to BUSY.
  - BUSY, cnt != 0: cnt decrements.
  - BUSY, cnt == 0: md_done=1, go to IDLE.
  - Latency: md_done occurs exactly MD_CYCLES cycles after md_start.
  - md_busy = (state == BUSY).
- md_stall = (hilo_rd_d || md_op_d) && (state == BUSY || hilo_wee).
  - This includes the launch cycle and the md_done cycle, so a reader enters E only after HI/LO has been written.
- Combined stall: any = lw_stall | br_stall | jr_stall | md_stall. Then stall_f = stall_d = flush_e = any.
- flush_e is only ever asserted together with stall_d. EXE bubbles have hilo_wee=0, so a held mult/div is never relaunched.
- hilo_wee while BUSY cannot occur (D is stalled). If it does, it is ignored and no md_start is issued.
- MD_CYCLES=1: cnt loads 0, md_done is issued on the next cycle.
- Reset values (synchronous, rst=1): state=IDLE, cnt=0, md_start=md_done=md_busy=0.
  - Reset mid-BUSY aborts the operation: no md_done is issued.
  - While rst=1, all stall, flush and forward outputs are forced to 0.

Optional Feature:
- Macro HAZARD_PERF_EN adds output ports stall_cnt[31:0] and md_cnt[31:0].
  - stall_cnt increments on every cycle with stall_d=1.
  - md_cnt increments on every md_start.
  - Both wrap at 2^32 and clear on rst.
- Without the macro, the ports and counters do not exist.

Decomposition:
- Package hazard_pkg holds:
  - fwd_e_t enum {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10};
  - DM2REG_MEM = 2'b01;
  - md_state_t enum {MD_IDLE, MD_BUSY}.
- Sub-module md_seq contains the FSM, counter, md_start/md_busy/md_done, and the md_stall term.
- hazard_ctrl contains the forward and stall decode and instantiates md_seq.

Test Plan:
- EX/MEM forward: we_regm=1, rf_wam=8, rse=8, we_regw=1, rf_waw=8 -> forward_ae=10. With rf_wam=0 and rse=0 -> forward_ae=00.
- Load-use: dm2rege=01, we_rege=1, rf_wae=9, rt_d=9 -> stall_f=stall_d=flush_e=1 for exactly one cycle. Next cycle, MEM forward gives forward_be=10.
- Branch: branch_d=1, rs_d=4, we_rege=1, rf_wae=4 -> one-cycle stall, then forward_ad=1 when the producer is in MEM.
- Mult/div: MD_CYCLES=4, hilo_wee pulse at cycle 0 -> md_start at 0, md_busy cycles 1..4, md_done at 4. With mfhi in D from cycle 0 -> stall_d=1 cycles 0..4, 0 at 5.
- Reset mid-op: rst=1 at cycle 2 of BUSY -> md_busy=0 next cycle, no md_done, stalls released.
- MD_CYCLES=1: md_done exactly one cycle after md_start. Back-to-back mult in D is stalled until md_done, then launches.
